// File: rtl/reg_bank_core.sv
// Register bank for the matrix-multiply datapath. It holds the general registers,
// the loop counters with zero flags, the shared bus mux and a pointer-addressed
// memory access engine.
//
// state | meaning
// IDLE  | no access pending; acc_start is accepted
// REQ   | mem_req held high until mem_ack, with no timeout
module reg_bank_core #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 16,
  parameter int NUM_CNT  = 2,
  parameter int NUM_PTR  = 4,
  localparam int SEL_W   = $clog2(NUM_REGS + 1),
  localparam int PTR_W   = (NUM_PTR > 1) ? $clog2(NUM_PTR) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_REGS-1:0] wr_en,
  input  logic [NUM_REGS-1:0] inc_en,
  input  logic [NUM_REGS-1:0] clr_en,
  input  logic [NUM_CNT-1:0]  dec_en,
  input  logic [NUM_CNT-1:0]  reload_en,
  input  logic [SEL_W-1:0]    bus_sel,
  input  logic [DATA_W-1:0]   ext_din,
  output logic [DATA_W-1:0]   bus,
  output logic [NUM_CNT-1:0]  z,
  input  logic                acc_start,
  input  logic                acc_we,
  input  logic [PTR_W-1:0]    acc_ptr,
  input  logic [SEL_W-2:0]    acc_dst,
  input  logic                acc_inc,
  output logic                busy,
  output logic                acc_done,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack
);

  localparam int PTR_BASE = NUM_REGS - NUM_PTR;

  typedef enum logic {IDLE, REQ} state_t;

  state_t                   state_q, state_d;
  logic                     we_q, we_d;
  logic                     inc_q, inc_d;
  logic                     done_q, done_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [SEL_W-2:0]         dst_q, dst_d;
  logic [DATA_W-1:0]        addr_q, addr_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic [DATA_W-1:0]        start_ptr_val;
  logic                     ack_fire;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;

  // Shared bus: registers, then the external source, anything above reads as 0.
  always_comb begin
    bus = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus_sel == SEL_W'(i)) bus = regs_flat[i*DATA_W +: DATA_W];
    end
    if (bus_sel == SEL_W'(NUM_REGS)) bus = ext_din;
  end

  // Value of the pointer register named by acc_ptr, captured as the address at start.
  always_comb begin
    start_ptr_val = '0;
    for (int p = 0; p < NUM_PTR; p++) begin
      if (acc_ptr == PTR_W'(p)) start_ptr_val = regs_flat[(PTR_BASE+p)*DATA_W +: DATA_W];
    end
  end

  // Access FSM next state; the request parameters are only latched from IDLE.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    inc_d    = inc_q;
    ptr_d    = ptr_q;
    dst_d    = dst_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    ack_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc_start) begin
          we_d    = acc_we;
          inc_d   = acc_inc;
          ptr_d   = acc_ptr;
          dst_d   = acc_dst;
          addr_d  = start_ptr_val;
          wdata_d = bus;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          ack_fire = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Access FSM and latched request registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      inc_q   <= 1'b0;
      done_q  <= 1'b0;
      ptr_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      inc_q   <= inc_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
      dst_q   <= dst_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Request outputs decode straight from the state so reset drops them at once.
  assign busy      = (state_q == REQ);
  assign mem_req   = busy;
  assign mem_we    = busy & we_q;
  assign acc_done  = done_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic [DATA_W-1:0] val_q, val_d, reload_val;
    logic              rd_hit, inc_hit, reload_req, dec_req;

    assign rd_hit = ack_fire & ~we_q & (dst_q == (SEL_W-1)'(i));

    if (i >= PTR_BASE) begin : g_ptr
      assign inc_hit = ack_fire & inc_q & (ptr_q == PTR_W'(i - PTR_BASE));
    end else begin : g_nptr
      assign inc_hit = 1'b0;
    end

    if (i < NUM_CNT) begin : g_cnt
      assign reload_req = reload_en[i];
      assign dec_req    = dec_en[i];
      assign reload_val = regs_flat[(NUM_CNT+i)*DATA_W +: DATA_W];
    end else begin : g_ncnt
      assign reload_req = 1'b0;
      assign dec_req    = 1'b0;
      assign reload_val = '0;
    end

    // Priority: read data, pointer bump, clear, load, reload, increment, decrement.
    always_comb begin
      val_d = val_q;
      if (rd_hit)                       val_d = mem_rdata;
      else if (inc_hit)                 val_d = val_q + DATA_W'(1);
      else if (clr_en[i])               val_d = '0;
      else if (wr_en[i])                val_d = bus;
      else if (reload_req)              val_d = reload_val;
      else if (inc_en[i])               val_d = val_q + DATA_W'(1);
      else if (dec_req && val_q != '0)  val_d = val_q - DATA_W'(1);
    end

    // Register storage.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) val_q <= '0;
      else     val_q <= val_d;
    end

    assign regs_flat[i*DATA_W +: DATA_W] = val_q;

    if (i < NUM_CNT) begin : g_z
      logic z_q;

      // Zero flag tracks the counter value written at the same edge.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) z_q <= 1'b1;
        else     z_q <= (val_d == '0);
      end

      assign z[i] = z_q;
    end
  end

endmodule

// File: tb/tb_reg_bank_core.sv
// Bench for reg_bank_core: directed plan steps plus randomized host operations and
// accesses, checked against an array-based reference model of the register bank.
module tb_reg_bank_core;
  localparam int DW = 8;
  localparam int NR = 16;
  localparam int NC = 2;
  localparam int NP = 4;
  localparam int SW = 5;
  localparam int PW = 2;
  localparam int PB = NR - NP;

  logic          CLK = 1'b0;
  logic          RST;
  logic [NR-1:0] wr_en, inc_en, clr_en;
  logic [NC-1:0] dec_en, reload_en;
  logic [SW-1:0] bus_sel;
  logic [DW-1:0] ext_din, bus;
  logic [NC-1:0] z;
  logic          acc_start, acc_we, acc_inc;
  logic [PW-1:0] acc_ptr;
  logic [SW-2:0] acc_dst;
  logic          busy, acc_done, mem_req, mem_we, mem_ack;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;

  reg_bank_core #(.DATA_W(DW), .NUM_REGS(NR), .NUM_CNT(NC), .NUM_PTR(NP)) dut (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .inc_en(inc_en), .clr_en(clr_en),
    .dec_en(dec_en), .reload_en(reload_en), .bus_sel(bus_sel), .ext_din(ext_din),
    .bus(bus), .z(z), .acc_start(acc_start), .acc_we(acc_we), .acc_ptr(acc_ptr),
    .acc_dst(acc_dst), .acc_inc(acc_inc), .busy(busy), .acc_done(acc_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #50 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned mdl[NR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int unsigned bus_model(input int sel, input int unsigned ext);
    if (sel < NR)       return mdl[sel];
    else if (sel == NR) return ext;
    else                return 0;
  endfunction

  function automatic logic [31:0] z_model();
    logic [31:0] r = '0;
    for (int k = 0; k < NC; k++) r[k] = (mdl[k] == 0);
    return r;
  endfunction

  // One edge with host operations applied to the model by the bank's priority rules.
  task automatic host_step();
    int unsigned old[NR];
    int unsigned bv;
    old = mdl;
    bv = bus_model(int'(bus_sel), int'(ext_din));
    for (int r = 0; r < NR; r++) begin
      if (clr_en[r])                      mdl[r] = 0;
      else if (wr_en[r])                  mdl[r] = bv;
      else if (r < NC && reload_en[r])    mdl[r] = old[NC + r];
      else if (inc_en[r])                 mdl[r] = (old[r] + 1) % 256;
      else if (r < NC && dec_en[r])       mdl[r] = (old[r] == 0) ? 0 : old[r] - 1;
    end
    tick();
    wr_en = '0; inc_en = '0; clr_en = '0; dec_en = '0; reload_en = '0;
  endtask

  task automatic chk_reg(input string tag, input int r, input logic [31:0] exp);
    bus_sel = SW'(r);
    #1;
    chk(tag, 32'(bus), exp);
  endtask

  task automatic check_all(input string tag);
    for (int r = 0; r < NR; r++) chk_reg($sformatf("%s R%0d", tag, r), r, mdl[r]);
    chk({tag, " z"}, 32'(z), z_model());
  endtask

  initial begin
    int unsigned exp_addr, exp_w, rd;
    int dly, p, d;
    logic w, inc;

    RST = 1'b1;
    wr_en = '0; inc_en = '0; clr_en = '0; dec_en = '0; reload_en = '0;
    bus_sel = '0; ext_din = '0; acc_start = 1'b0; acc_we = 1'b0; acc_ptr = '0;
    acc_dst = '0; acc_inc = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    for (int r = 0; r < NR; r++) mdl[r] = 0;
    #3;
    chk("rst busy", 32'(busy), 0);
    chk("rst acc_done", 32'(acc_done), 0);
    chk("rst mem_req", 32'(mem_req), 0);
    chk("rst mem_we", 32'(mem_we), 0);
    chk("rst mem_addr", 32'(mem_addr), 0);
    chk("rst mem_wdata", 32'(mem_wdata), 0);
    chk("rst z", 32'(z), 32'h3);
    check_all("rst");
    @(negedge CLK);
    RST = 1'b0;

    // basic load and increment
    bus_sel = SW'(NR); ext_din = 8'h3C; wr_en[5] = 1'b1; host_step();
    chk_reg("basic wr R5", 5, 32'h3C);
    inc_en[5] = 1'b1; host_step();
    chk_reg("basic inc1 R5", 5, 32'h3D);
    inc_en[5] = 1'b1; host_step();
    chk_reg("basic inc2 R5", 5, 32'h3E);

    // counter reload and saturating decrement
    bus_sel = SW'(NR); ext_din = 8'h03; wr_en[2] = 1'b1; host_step();
    reload_en[0] = 1'b1; host_step();
    chk_reg("cnt reload R0", 0, 32'h3);
    chk("cnt reload z0", 32'(z[0]), 0);
    for (int i = 0; i < 4; i++) begin
      dec_en[0] = 1'b1; host_step();
      chk_reg($sformatf("cnt dec%0d R0", i), 0, (i < 3) ? 32'(2 - i) : 32'h0);
      chk($sformatf("cnt dec%0d z0", i), 32'(z[0]), (i >= 2) ? 32'h1 : 32'h0);
    end

    // priority
    bus_sel = SW'(NR); ext_din = 8'h55;
    clr_en[7] = 1'b1; wr_en[7] = 1'b1; inc_en[7] = 1'b1; host_step();
    chk_reg("prio clr R7", 7, 32'h0);
    bus_sel = SW'(NR); ext_din = 8'h55;
    wr_en[7] = 1'b1; inc_en[7] = 1'b1; host_step();
    chk_reg("prio wr R7", 7, 32'h55);
    check_all("prio");

    // random host operations; stray acks while idle must be ignored
    repeat (120) begin
      wr_en     = NR'($urandom & $urandom & $urandom);
      inc_en    = NR'($urandom & $urandom);
      clr_en    = NR'($urandom & $urandom & $urandom);
      dec_en    = NC'($urandom);
      reload_en = NC'($urandom & $urandom);
      bus_sel   = SW'($urandom_range(0, 20));
      ext_din   = DW'($urandom);
      mem_ack   = 1'($urandom);
      mem_rdata = DW'($urandom);
      host_step();
      mem_ack = 1'b0;
      chk("rand idle busy", 32'(busy), 0);
      check_all("rand");
    end

    // read access with post-increment, ack in the third REQ cycle
    bus_sel = SW'(NR); ext_din = 8'hFF; wr_en[12] = 1'b1; host_step();
    acc_we = 1'b0; acc_ptr = 2'd0; acc_dst = 4'd6; acc_inc = 1'b1; acc_start = 1'b1;
    tick();
    acc_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rd req%0d busy", i), 32'(busy), 1);
      chk($sformatf("rd req%0d mem_req", i), 32'(mem_req), 1);
      chk($sformatf("rd req%0d mem_we", i), 32'(mem_we), 0);
      chk($sformatf("rd req%0d mem_addr", i), 32'(mem_addr), 32'hFF);
      chk($sformatf("rd req%0d acc_done", i), 32'(acc_done), 0);
      if (i == 0) begin
        acc_start = 1'b1; acc_ptr = 2'd3; acc_dst = 4'd1;
        tick();
        acc_start = 1'b0;
      end else if (i == 1) begin
        tick();
      end
    end
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    tick();
    mem_ack = 1'b0;
    mdl[6] = 32'hA5; mdl[12] = 0;
    chk("rd done acc_done", 32'(acc_done), 1);
    chk("rd done mem_req", 32'(mem_req), 0);
    chk("rd done busy", 32'(busy), 0);
    chk_reg("rd R6", 6, 32'hA5);
    chk_reg("rd R12", 12, 32'h00);
    check_all("rd");
    tick();
    chk("rd done pulse", 32'(acc_done), 0);

    // back-to-back writes, second start in the acc_done cycle
    bus_sel = SW'(NR); ext_din = 8'h11;
    acc_we = 1'b1; acc_ptr = 2'd1; acc_inc = 1'b0; acc_start = 1'b1;
    exp_addr = mdl[13];
    tick();
    acc_start = 1'b0;
    chk("wr1 mem_req", 32'(mem_req), 1);
    chk("wr1 mem_we", 32'(mem_we), 1);
    chk("wr1 mem_addr", 32'(mem_addr), exp_addr);
    chk("wr1 mem_wdata", 32'(mem_wdata), 32'h11);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("wr1 gap mem_req", 32'(mem_req), 0);
    chk("wr1 acc_done", 32'(acc_done), 1);
    bus_sel = SW'(NR); ext_din = 8'h22; acc_inc = 1'b1; acc_start = 1'b1;
    exp_addr = mdl[13];
    tick();
    acc_start = 1'b0;
    chk("wr2 mem_req", 32'(mem_req), 1);
    chk("wr2 mem_we", 32'(mem_we), 1);
    chk("wr2 acc_done", 32'(acc_done), 0);
    chk("wr2 mem_wdata", 32'(mem_wdata), 32'h22);
    chk("wr2 mem_addr", 32'(mem_addr), exp_addr);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    mdl[13] = (mdl[13] + 1) % 256;
    chk("wr2 mem_req off", 32'(mem_req), 0);
    chk("wr2 acc_done", 32'(acc_done), 1);
    check_all("wr2");
    tick();
    chk("wr2 done pulse", 32'(acc_done), 0);

    // random accesses chained back-to-back
    repeat (30) begin
      p = $urandom_range(0, NP - 1);
      d = $urandom_range(0, NR - 1);
      w = 1'($urandom);
      inc = 1'($urandom);
      bus_sel = SW'($urandom_range(0, 20));
      ext_din = DW'($urandom);
      exp_addr = mdl[PB + p];
      exp_w = bus_model(int'(bus_sel), int'(ext_din));
      acc_we = w; acc_ptr = PW'(p); acc_dst = (SW-1)'(d); acc_inc = inc; acc_start = 1'b1;
      tick();
      acc_start = 1'b0;
      dly = $urandom_range(0, 3);
      for (int i = 0; i < dly; i++) begin
        chk("racc wait mem_req", 32'(mem_req), 1);
        tick();
      end
      chk("racc mem_req", 32'(mem_req), 1);
      chk("racc mem_we", 32'(mem_we), 32'(w));
      chk("racc mem_addr", 32'(mem_addr), exp_addr);
      chk("racc mem_wdata", 32'(mem_wdata), exp_w);
      rd = $urandom_range(0, 255);
      mem_rdata = DW'(rd); mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      if (!w) mdl[d] = rd;
      if (inc && !(!w && d == PB + p)) mdl[PB + p] = (mdl[PB + p] + 1) % 256;
      chk("racc acc_done", 32'(acc_done), 1);
      chk("racc busy", 32'(busy), 0);
      check_all("racc");
    end
    tick();
    chk("racc done pulse", 32'(acc_done), 0);

    // reset in the middle of a read
    acc_we = 1'b0; acc_dst = 4'd9; acc_ptr = 2'd2; acc_inc = 1'b1; acc_start = 1'b1;
    tick();
    acc_start = 1'b0;
    chk("rstmid mem_req before", 32'(mem_req), 1);
    #10;
    RST = 1'b1;
    #1;
    chk("rstmid mem_req", 32'(mem_req), 0);
    chk("rstmid busy", 32'(busy), 0);
    chk("rstmid mem_we", 32'(mem_we), 0);
    for (int r = 0; r < NR; r++) mdl[r] = 0;
    mem_ack = 1'b1; mem_rdata = 8'h77;
    tick();
    chk("rstmid acc_done", 32'(acc_done), 0);
    @(negedge CLK);
    RST = 1'b0;
    tick();
    mem_ack = 1'b0;
    chk("rstmid after acc_done", 32'(acc_done), 0);
    chk("rstmid after busy", 32'(busy), 0);
    chk_reg("rstmid R9", 9, 32'h0);
    check_all("rstmid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
